// File: rtl/wb_target_mem_pkg.sv
// Shared types and helpers for the Wishbone target memory.
// Holds the FSM state encoding, the wait-counter width and the byte-lane address helper.
package wb_target_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_tgt_state_e;

   localparam int unsigned WAIT_CNT_W = 4;

   // Number of low address bits that select a byte within one data word.
   function automatic int unsigned lane_lsb(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/wb_target_mem_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register can also be cleared, which is how error responses return zero data.
module wb_target_mem_ram #(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [$clog2(DEPTH)-1:0]    addr,
   input  logic                        we,
   input  logic [DATA_WIDTH/8-1:0]     be,
   input  logic [DATA_WIDTH-1:0]       wdata,
   input  logic                        re,
   input  logic                        clr,
   output logic [DATA_WIDTH-1:0]       rdata
);

   localparam int unsigned LANES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clock) begin
      if (we) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (be[i]) begin
               mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (clr) begin
         rdata_d = '0;
      end else if (re) begin
         rdata_d = mem[addr];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/wb_target_mem.sv
// Classic Wishbone target: byte-enabled word RAM with programmable wait states
// and an error termination for addresses outside the decoded window.
module wb_target_mem
   import wb_target_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH       = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     adr,
   input  logic [DATA_WIDTH-1:0]     dat_w,
   output logic [DATA_WIDTH-1:0]     dat_r,
   input  logic                      stb,
   input  logic                      cyc,
   input  logic                      we,
   input  logic [DATA_WIDTH/8-1:0]   sel,
   output logic                      ack,
   output logic                      err
);

   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam int unsigned LSB   = lane_lsb(DATA_WIDTH);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] WIN_LO   = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] WIN_SIZE = (ADDR_WIDTH+1)'(DEPTH * LANES);
   localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
      (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

   wb_tgt_state_e         state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  we_q, we_d;
   logic [LANES-1:0]      sel_q, sel_d;
   logic [DATA_WIDTH-1:0] dat_w_q, dat_w_d;
   logic                  in_range_q, in_range_d;

   logic                  req;
   logic [ADDR_WIDTH:0]   adr_off;
   logic                  adr_in_range;
   logic                  enter_resp;

   assign req = cyc & stb;

   // Addresses below the base wrap to a large offset, so one compare covers both bounds.
   assign adr_off      = {1'b0, adr} - WIN_LO;
   assign adr_in_range = adr_off < WIN_SIZE;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         sel_q      <= '0;
         dat_w_q    <= '0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         dat_w_q    <= dat_w_d;
         in_range_q <= in_range_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      we_d       = we_q;
      sel_d      = sel_q;
      dat_w_d    = dat_w_q;
      in_range_d = in_range_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d      = adr[LSB +: IDX_W];
               we_d       = we;
               sel_d      = sel;
               dat_w_d    = dat_w;
               in_range_d = adr_in_range;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The *_d copies are the transfer attributes on the RESP-entry edge, whether
   // that edge comes straight from IDLE or at the end of WAIT.
   assign enter_resp = (state_d == RESP) && (state_q != RESP) && !reset;

   wb_target_mem_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .addr  (idx_d),
      .we    (enter_resp && in_range_d && we_d),
      .be    (sel_d),
      .wdata (dat_w_d),
      .re    (enter_resp && in_range_d && !we_d),
      .clr   (enter_resp && !in_range_d),
      .rdata (dat_r)
   );

   always_comb begin
      ack = 1'b0;
      err = 1'b0;
      if (state_q == RESP) begin
         ack = in_range_q;
         err = !in_range_q;
      end
   end

endmodule

// File: tb/tb_wb_target_mem.sv
// Directed bench for wb_target_mem: one zero-wait target at base 0 and one
// three-wait-state target at a non-zero base, sharing the request bus.
module tb_wb_target_mem;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] adr   = '0;
   logic [31:0] dat_w = '0;
   logic        we    = 1'b0;
   logic [3:0]  sel   = '0;
   logic        stb   = 1'b0;
   logic        cyc_a = 1'b0;
   logic        cyc_b = 1'b0;
   logic [31:0] dat_r_a, dat_r_b;
   logic        ack_a, ack_b, err_a, err_b;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic prev_ack_a = 1'b0, prev_err_a = 1'b0, prev_ack_b = 1'b0, prev_err_b = 1'b0;

   always #5 clock = ~clock;

   wb_target_mem #(
      .WAIT_STATES (0)
   ) u_a (
      .clock (clock), .reset (reset), .adr (adr), .dat_w (dat_w), .dat_r (dat_r_a),
      .stb (stb), .cyc (cyc_a), .we (we), .sel (sel), .ack (ack_a), .err (err_a)
   );

   wb_target_mem #(
      .DEPTH       (256),
      .BASE_ADDR   (32'h0001_0000),
      .WAIT_STATES (3)
   ) u_b (
      .clock (clock), .reset (reset), .adr (adr), .dat_w (dat_w), .dat_r (dat_r_b),
      .stb (stb), .cyc (cyc_b), .we (we), .sel (sel), .ack (ack_b), .err (err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response exclusivity and single-cycle pulses, checked every cycle.
   always @(negedge clock) begin
      if (mon_en) begin
         check("excl_a",  32'(ack_a & err_a), 32'd0);
         check("excl_b",  32'(ack_b & err_b), 32'd0);
         check("pulse_a", 32'((ack_a & prev_ack_a) | (err_a & prev_err_a)), 32'd0);
         check("pulse_b", 32'((ack_b & prev_ack_b) | (err_b & prev_err_b)), 32'd0);
      end
      prev_ack_a = ack_a;
      prev_err_a = err_a;
      prev_ack_b = ack_b;
      prev_err_b = err_b;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic xfer(input bit tgt, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int exp_lat, input bit exp_err,
                       input bit chk_d, input logic [31:0] exp_d, input string tag);
      int   lat;
      logic r_ack, r_err, r_ack2, r_err2;
      @(negedge clock);
      adr = a; dat_w = d; we = w; sel = s; stb = 1'b1;
      cyc_a = !tgt; cyc_b = tgt;
      lat = 0; r_ack = 1'b0; r_err = 1'b0;
      while (!(r_ack || r_err) && lat < 20) begin
         @(negedge clock);
         lat++;
         r_ack = tgt ? ack_b : ack_a;
         r_err = tgt ? err_b : err_a;
      end
      stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_ack"}, 32'(r_ack), 32'(!exp_err));
      check({tag, "_err"}, 32'(r_err), 32'(exp_err));
      if (chk_d) check({tag, "_dat"}, tgt ? dat_r_b : dat_r_a, exp_d);
      @(negedge clock);
      r_ack2 = tgt ? ack_b : ack_a;
      r_err2 = tgt ? err_b : err_a;
      check({tag, "_end"}, 32'(r_ack2 | r_err2), 32'd0);
   endtask

   initial begin
      // reset and idle bus
      repeat (3) @(negedge clock);
      reset = 1'b0;
      mon_en = 1'b1;
      check("rst_ack_a", 32'(ack_a), 32'd0);
      check("rst_err_a", 32'(err_a), 32'd0);
      check("rst_dat_a", dat_r_a, 32'd0);
      check("rst_ack_b", 32'(ack_b), 32'd0);
      check("rst_err_b", 32'(err_b), 32'd0);
      check("rst_dat_b", dat_r_b, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("idle_resp", 32'(ack_a | err_a | ack_b | err_b), 32'd0);
      end

      // zero wait states: write then read back
      xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 0, '0, "a_wr10");
      xfer(0, 0, 32'h10, 32'h0,        4'hF, 1, 0, 1, 32'hDEADBEEF, "a_rd10");

      // byte lanes, then sel==0 write leaves the word untouched
      xfer(0, 1, 32'h20, 32'h11223344, 4'hF,    1, 0, 0, '0, "a_wr20");
      xfer(0, 1, 32'h22, 32'hAABBCCDD, 4'b0101, 1, 0, 0, '0, "a_wr20_lane");
      xfer(0, 0, 32'h20, 32'h0,        4'h0,    1, 0, 1, 32'h11BB33DD, "a_rd20");
      xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0,    1, 0, 0, '0, "a_wr20_sel0");
      xfer(0, 0, 32'h20, 32'h0,        4'hF,    1, 0, 1, 32'h11BB33DD, "a_rd20_b");

      // request held through RESP: a second, separate transfer
      @(negedge clock);
      adr = 32'h10; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc_a = 1'b1;
      @(negedge clock);
      check("b2b_ack1", 32'(ack_a), 32'd1);
      @(negedge clock);
      check("b2b_gap", 32'(ack_a), 32'd0);
      @(negedge clock);
      check("b2b_ack2", 32'(ack_a), 32'd1);
      check("b2b_dat", dat_r_a, 32'hDEADBEEF);
      stb = 1'b0; cyc_a = 1'b0;
      @(negedge clock);
      check("b2b_end", 32'(ack_a), 32'd0);

      // three wait states, window boundaries of the offset target
      xfer(1, 1, 32'h0001_0010, 32'hCAFEF00D, 4'hF, 4, 0, 0, '0, "b_wr10");
      xfer(1, 0, 32'h0001_0010, 32'h0,        4'hF, 4, 0, 1, 32'hCAFEF00D, "b_rd10");
      xfer(1, 1, 32'h0001_03FC, 32'h0BADC0DE, 4'hF, 4, 0, 0, '0, "b_wr_last");
      xfer(1, 0, 32'h0001_03FC, 32'h0,        4'hF, 4, 0, 1, 32'h0BADC0DE, "b_rd_last");
      xfer(1, 0, 32'h0001_0400, 32'h0,        4'hF, 4, 1, 1, 32'h0, "b_rd_above");
      xfer(1, 0, 32'h0001_03FC, 32'h0,        4'hF, 4, 0, 1, 32'h0BADC0DE, "b_rd_last2");
      xfer(1, 0, 32'h0000_FFFC, 32'h0,        4'hF, 4, 1, 1, 32'h0, "b_rd_below");

      // abort a write by dropping cyc during WAIT
      @(negedge clock);
      adr = 32'h0001_0010; dat_w = 32'h12345678; we = 1'b1; sel = 4'hF;
      stb = 1'b1; cyc_b = 1'b1;
      @(negedge clock);
      @(negedge clock);
      cyc_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("abort_quiet", 32'(ack_b | err_b), 32'd0);
      end
      stb = 1'b0;
      xfer(1, 0, 32'h0001_0010, 32'h0, 4'hF, 4, 0, 1, 32'hCAFEF00D, "b_rd_after_abort");

      // out-of-range write aliases word 0 by index but must not touch it
      xfer(0, 1, 32'h0,    32'h5A5A5A5A, 4'hF, 1, 0, 0, '0, "a_wr0");
      xfer(0, 0, 32'h0,    32'h0,        4'hF, 1, 0, 1, 32'h5A5A5A5A, "a_rd0");
      xfer(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 1, 1, 32'h0, "a_wr_oor");
      xfer(0, 0, 32'h0,    32'h0,        4'hF, 1, 0, 1, 32'h5A5A5A5A, "a_rd0_after");

      // reset during WAIT: no response, write discarded
      @(negedge clock);
      adr = 32'h0001_0010; dat_w = 32'h77777777; we = 1'b1; sel = 4'hF;
      stb = 1'b1; cyc_b = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; stb = 1'b0; cyc_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("rst_mid_quiet", 32'(ack_b | err_b), 32'd0);
      end
      xfer(1, 0, 32'h0001_0010, 32'h0, 4'hF, 4, 0, 1, 32'hCAFEF00D, "b_rd_after_rst");

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
